// File: rtl/instr_fetch_mem.sv
// Synchronous instruction memory with a 1-cycle registered fetch port, program-load
// write port, stall/flush control, range/alignment fault detection and field decode.
module instr_fetch_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned BYTE_ADDR = 0,
  parameter string       INIT_FILE = "",
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc,
  input  logic              fetch_req,
  output logic              fetch_rdy,
  input  logic              stall,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              inst_valid,
  output logic              inst_fault,
  output logic [DATA_W-1:0] inst,
  output logic [31:0]       pc_out,
  output logic [5:0]        opcode,
  output logic [4:0]        r_reg1,
  output logic [4:0]        r_reg2,
  output logic [4:0]        w_reg,
  output logic [4:0]        shift,
  output logic [5:0]        funct,
  output logic [15:0]       inst_16bit,
  output logic [31:0]       imm_sext,
  output logic [25:0]       jaddr,
  output logic [31:0]       fetch_cnt
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       idx;
  logic              fault;
  logic              accept;

  always_comb begin
    idx    = (BYTE_ADDR != 0) ? {2'b00, pc[31:2]} : pc;
    fault  = (idx >= DEPTH) || ((BYTE_ADDR != 0) && (pc[1:0] != 2'b00));
    accept = fetch_req && !stall;
  end

  assign fetch_rdy = ~stall;

  // Memory is deliberately outside the reset domain so loaded programs survive rst_n.
  always_ff @(posedge clk) begin
    if (ld_en && (32'(ld_addr) < DEPTH)) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // The fetch reads mem with the pre-edge contents, so a same-cycle load is read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst_fault <= 1'b0;
      inst       <= '0;
      pc_out     <= '0;
      fetch_cnt  <= '0;
    end else if (accept) begin
      inst_valid <= 1'b1;
      inst_fault <= fault;
      inst       <= fault ? '0 : mem[idx[AW-1:0]];
      pc_out     <= pc;
      fetch_cnt  <= fetch_cnt + 32'd1;
    end else if (flush || !stall) begin
      inst_valid <= 1'b0;
      inst_fault <= 1'b0;
    end
  end

  always_comb begin
    opcode     = inst[31:26];
    r_reg1     = inst[25:21];
    r_reg2     = inst[20:16];
    w_reg      = inst[15:11];
    shift      = inst[10:6];
    funct      = inst[5:0];
    inst_16bit = inst[15:0];
    imm_sext   = {{16{inst[15]}}, inst[15:0]};
    jaddr      = inst[25:0];
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: a word-indexed and a byte-addressed instance
// share clock, reset and load port; expected fetch results are queued at drive time.
module tb_instr_fetch_mem;

  typedef struct {
    logic        v;
    logic        f;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  logic        clk, rst_n;
  logic [31:0] pc, pc_b;
  logic        fetch_req, stall, flush, ld_en;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;

  logic        fetch_rdy, inst_valid, inst_fault;
  logic [31:0] inst, pc_out, imm_sext, fetch_cnt;
  logic [5:0]  opcode, funct;
  logic [4:0]  r_reg1, r_reg2, w_reg, shift;
  logic [15:0] inst_16bit;
  logic [25:0] jaddr;

  logic        fetch_rdy_b, inst_valid_b, inst_fault_b;
  logic [31:0] inst_b, pc_out_b, imm_sext_b, fetch_cnt_b;
  logic [5:0]  opcode_b, funct_b;
  logic [4:0]  r_reg1_b, r_reg2_b, w_reg_b, shift_b;
  logic [15:0] inst_16bit_b;
  logic [25:0] jaddr_b;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] tb_mem [128];
  logic [31:0] exp_cnt;
  int          passed, total;

  instr_fetch_mem #(.DATA_W(32), .DEPTH(128), .BYTE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_req(fetch_req), .fetch_rdy(fetch_rdy),
    .stall(stall), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .inst_valid(inst_valid), .inst_fault(inst_fault), .inst(inst), .pc_out(pc_out),
    .opcode(opcode), .r_reg1(r_reg1), .r_reg2(r_reg2), .w_reg(w_reg), .shift(shift),
    .funct(funct), .inst_16bit(inst_16bit), .imm_sext(imm_sext), .jaddr(jaddr),
    .fetch_cnt(fetch_cnt)
  );

  instr_fetch_mem #(.DATA_W(32), .DEPTH(128), .BYTE_ADDR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pc(pc_b), .fetch_req(fetch_req), .fetch_rdy(fetch_rdy_b),
    .stall(stall), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .inst_valid(inst_valid_b), .inst_fault(inst_fault_b), .inst(inst_b), .pc_out(pc_out_b),
    .opcode(opcode_b), .r_reg1(r_reg1_b), .r_reg2(r_reg2_b), .w_reg(w_reg_b), .shift(shift_b),
    .funct(funct_b), .inst_16bit(inst_16bit_b), .imm_sext(imm_sext_b), .jaddr(jaddr_b),
    .fetch_cnt(fetch_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1);
  end

  // All stimulus tasks begin just after a falling edge and return just after one.
  task automatic load(input logic [6:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    tb_mem[a] = d;
    ld_en = 1'b0;
  endtask

  task automatic drive_fetch(input logic [31:0] p);
    exp_t x;
    pc = p;
    fetch_req = 1'b1;
    exp_cnt = exp_cnt + 32'd1;
    x.v = 1'b1;
    x.f = (p >= 32'd128);
    x.inst = x.f ? 32'h0 : tb_mem[p[6:0]];
    x.pc = p;
    x.cnt = exp_cnt;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== '0)
      $display("FAIL reset_state: got v=%b f=%b inst=%h pc=%h cnt=%h want all 0",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt);
    else passed++;
    load(7'd0, 32'h00221820);
    drive_fetch(32'd0);
    @(negedge clk);
    fetch_req = 1'b0;
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {e.v, e.f, e.inst, e.pc, e.cnt})
      $display("FAIL pre_reset_fetch: got v=%b f=%b inst=%h pc=%h cnt=%h want v=%b f=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.v, e.f, e.inst, e.pc, e.cnt);
    else passed++;
    pc = 32'd0; fetch_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== '0)
      $display("FAIL async_reset: got v=%b f=%b inst=%h pc=%h cnt=%h want all 0",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1; fetch_req = 1'b0;
    exp_cnt = 32'd0;
    @(negedge clk);
    total++;
    if ({inst_valid, fetch_cnt} !== 33'd0)
      $display("FAIL reset_drops_fetch: got v=%b cnt=%h want v=0 cnt=0", inst_valid, fetch_cnt);
    else passed++;
    // memory survives reset
    drive_fetch(32'd0);
    @(negedge clk);
    fetch_req = 1'b0;
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst, fetch_cnt} !== {1'b1, 32'h00221820, 32'd1})
      $display("FAIL mem_survives_reset: got v=%b inst=%h cnt=%h want v=1 inst=00221820 cnt=1",
               inst_valid, inst, fetch_cnt);
    else passed++;
  endtask

  task automatic test_decode;
    load(7'd0, 32'h00221820);
    drive_fetch(32'd0);
    @(negedge clk);
    fetch_req = 1'b0;
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {e.v, e.f, e.inst, e.pc, e.cnt})
      $display("FAIL decode_fetch: got v=%b f=%b inst=%h pc=%h cnt=%h want v=%b f=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.v, e.f, e.inst, e.pc, e.cnt);
    else passed++;
    total++;
    if ({opcode, r_reg1, r_reg2, w_reg, shift, funct} !== {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20})
      $display("FAIL decode_fields: got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h want op=0 rs=1 rt=2 rd=3 sh=0 fn=20",
               opcode, r_reg1, r_reg2, w_reg, shift, funct);
    else passed++;
  endtask

  task automatic test_imm;
    load(7'd5, 32'h2021FFFC);
    pc_b = 32'd20;
    drive_fetch(32'd5);
    @(negedge clk);
    fetch_req = 1'b0;
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {e.v, e.f, e.inst, e.pc, e.cnt})
      $display("FAIL imm_fetch: got v=%b f=%b inst=%h pc=%h cnt=%h want v=%b f=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.v, e.f, e.inst, e.pc, e.cnt);
    else passed++;
    total++;
    if ({imm_sext, opcode, inst_16bit, jaddr} !== {32'hFFFFFFFC, 6'h08, 16'hFFFC, 26'h021FFFC})
      $display("FAIL imm_fields: got imm=%h op=%h i16=%h j=%h want imm=fffffffc op=08 i16=fffc j=021fffc",
               imm_sext, opcode, inst_16bit, jaddr);
    else passed++;
    total++;
    if ({inst_valid_b, inst_fault_b, inst_b, pc_out_b, imm_sext_b} !== {1'b1, 1'b0, 32'h2021FFFC, 32'd20, 32'hFFFFFFFC})
      $display("FAIL byte_addr_fetch: got v=%b f=%b inst=%h pc=%h imm=%h want v=1 f=0 inst=2021fffc pc=14 imm=fffffffc",
               inst_valid_b, inst_fault_b, inst_b, pc_out_b, imm_sext_b);
    else passed++;
    pc_b = 32'd0;
  endtask

  task automatic test_fault;
    load(7'd127, 32'hDEADBEEF);
    pc_b = 32'd6;
    drive_fetch(32'd128);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {e.v, e.f, e.inst, e.pc, e.cnt})
      $display("FAIL range_fault: got v=%b f=%b inst=%h pc=%h cnt=%h want v=%b f=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.v, e.f, e.inst, e.pc, e.cnt);
    else passed++;
    total++;
    if ({inst_valid_b, inst_fault_b, inst_b, imm_sext_b} !== {1'b1, 1'b1, 32'h0, 32'h0})
      $display("FAIL misalign_fault: got v=%b f=%b inst=%h imm=%h want v=1 f=1 inst=0 imm=0",
               inst_valid_b, inst_fault_b, inst_b, imm_sext_b);
    else passed++;
    pc_b = 32'd512;
    drive_fetch(32'd127);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {e.v, e.f, e.inst, e.pc, e.cnt})
      $display("FAIL last_index_clears_fault: got v=%b f=%b inst=%h pc=%h cnt=%h want v=%b f=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.v, e.f, e.inst, e.pc, e.cnt);
    else passed++;
    total++;
    if ({inst_valid_b, inst_fault_b, inst_b} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL byte_range_fault: got v=%b f=%b inst=%h want v=1 f=1 inst=0",
               inst_valid_b, inst_fault_b, inst_b);
    else passed++;
    pc_b = 32'd508;
    drive_fetch(32'd128);
    @(negedge clk);
    fetch_req = 1'b0;
    e = sb.pop_front();
    total++;
    if ({inst_valid_b, inst_fault_b, inst_b} !== {1'b1, 1'b0, 32'hDEADBEEF})
      $display("FAIL byte_last_index: got v=%b f=%b inst=%h want v=1 f=0 inst=deadbeef",
               inst_valid_b, inst_fault_b, inst_b);
    else passed++;
    @(negedge clk);
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {1'b0, 1'b0, e.inst, e.pc, e.cnt})
      $display("FAIL idle_hold: got v=%b f=%b inst=%h pc=%h cnt=%h want v=0 f=0 inst=%h pc=%h cnt=%h",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.inst, e.pc, e.cnt);
    else passed++;
    pc_b = 32'd0;
  endtask

  task automatic test_stall_flush;
    drive_fetch(32'd0);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst, pc_out, fetch_cnt} !== {e.v, e.inst, e.pc, e.cnt})
      $display("FAIL pre_stall_fetch: got v=%b inst=%h pc=%h cnt=%h want v=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst, pc_out, fetch_cnt, e.v, e.inst, e.pc, e.cnt);
    else passed++;
    stall = 1'b1; fetch_req = 1'b1; pc = 32'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (fetch_rdy !== 1'b0)
        $display("FAIL stall_rdy: got fetch_rdy=%b want 0", fetch_rdy);
      else passed++;
      @(negedge clk);
      total++;
      if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {1'b1, 1'b0, e.inst, e.pc, e.cnt})
        $display("FAIL stall_hold: got v=%b f=%b inst=%h pc=%h cnt=%h want v=1 f=0 inst=%h pc=%h cnt=%h",
                 inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.inst, e.pc, e.cnt);
      else passed++;
    end
    flush = 1'b1;
    @(negedge clk);
    total++;
    if ({inst_valid, inst, pc_out, fetch_cnt} !== {1'b0, e.inst, e.pc, e.cnt})
      $display("FAIL flush_over_stall: got v=%b inst=%h pc=%h cnt=%h want v=0 inst=%h pc=%h cnt=%h",
               inst_valid, inst, pc_out, fetch_cnt, e.inst, e.pc, e.cnt);
    else passed++;
    stall = 1'b0;
    #1;
    total++;
    if (fetch_rdy !== 1'b1)
      $display("FAIL rdy_after_stall: got fetch_rdy=%b want 1", fetch_rdy);
    else passed++;
    drive_fetch(32'd5);
    @(negedge clk);
    fetch_req = 1'b0;
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst_fault, inst, pc_out, fetch_cnt} !== {e.v, e.f, e.inst, e.pc, e.cnt})
      $display("FAIL flush_with_fetch: got v=%b f=%b inst=%h pc=%h cnt=%h want v=%b f=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst_fault, inst, pc_out, fetch_cnt, e.v, e.f, e.inst, e.pc, e.cnt);
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if ({inst_valid, inst, pc_out} !== {1'b0, e.inst, e.pc})
      $display("FAIL flush_alone: got v=%b inst=%h pc=%h want v=0 inst=%h pc=%h",
               inst_valid, inst, pc_out, e.inst, e.pc);
    else passed++;
  endtask

  task automatic test_load_collision;
    load(7'd7, 32'h11111111);
    ld_en = 1'b1; ld_addr = 7'd7; ld_data = 32'h22222222;
    drive_fetch(32'd7);
    @(negedge clk);
    ld_en = 1'b0;
    tb_mem[7] = 32'h22222222;
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst, pc_out, fetch_cnt} !== {e.v, e.inst, e.pc, e.cnt})
      $display("FAIL read_before_write: got v=%b inst=%h pc=%h cnt=%h want v=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst, pc_out, fetch_cnt, e.v, e.inst, e.pc, e.cnt);
    else passed++;
    drive_fetch(32'd7);
    @(negedge clk);
    fetch_req = 1'b0;
    e = sb.pop_front();
    total++;
    if ({inst_valid, inst, pc_out, fetch_cnt} !== {e.v, e.inst, e.pc, e.cnt})
      $display("FAIL new_word_after_load: got v=%b inst=%h pc=%h cnt=%h want v=%b inst=%h pc=%h cnt=%h",
               inst_valid, inst, pc_out, fetch_cnt, e.v, e.inst, e.pc, e.cnt);
    else passed++;
  endtask

  task automatic test_cnt_wrap;
    force dut.fetch_cnt = 32'hFFFFFFFE;
    #1 release dut.fetch_cnt;
    exp_cnt = 32'hFFFFFFFE;
    for (int i = 0; i < 2; i++) begin
      drive_fetch(32'd0);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (fetch_cnt !== e.cnt)
        $display("FAIL cnt_wrap: step %0d got cnt=%h want %h", i, fetch_cnt, e.cnt);
      else passed++;
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0; exp_cnt = 32'd0;
    rst_n = 1'b0; pc = '0; pc_b = '0; fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 128; i++) tb_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_decode;
    test_imm;
    test_fault;
    test_stall_flush;
    test_load_collision;
    test_cnt_wrap;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
